// File: rtl/read_axi256_if.sv
// AR/R read channels toward DDR plus the AXI4-Stream playback port of read_axi256.
// The master modport is the read_axi256 side; slave is the memory/fabric side.
interface read_axi256_if #(
   parameter int ADDR_W = 48,
   parameter int DATA_W = 256
);
   logic [ADDR_W-1:0] m_axi_araddr;
   logic [7:0]        m_axi_arlen;
   logic [2:0]        m_axi_arsize;
   logic [1:0]        m_axi_arburst;
   logic              m_axi_arvalid;
   logic              m_axi_arready;
   logic [DATA_W-1:0] m_axi_rdata;
   logic [1:0]        m_axi_rresp;
   logic              m_axi_rlast;
   logic              m_axi_rvalid;
   logic              m_axi_rready;
   logic [DATA_W-1:0] m_axis_tdata;
   logic              m_axis_tlast;
   logic              m_axis_tvalid;
   logic              m_axis_tready;

   modport master (
      output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
      input  m_axi_arready,
      input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
      output m_axi_rready,
      output m_axis_tdata, m_axis_tlast, m_axis_tvalid,
      input  m_axis_tready
   );

   modport slave (
      input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
      output m_axi_arready,
      output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
      input  m_axi_rready,
      input  m_axis_tdata, m_axis_tlast, m_axis_tvalid,
      output m_axis_tready
   );
endinterface

// File: rtl/read_axi256.sv
// AXI4 read master: plays a contiguous block of 256-bit words from DDR out as an AXI4-Stream.
// Bursts are only issued once the output FIFO has room for them, so R is never stalled.
//
// state  | meaning
// IDLE   | waiting for start
// ISSUE  | issuing AR bursts as credits allow
// DRAIN  | all bursts issued, waiting for the last stream beat
// FINISH | one cycle: pulse done, drop busy
module read_axi256 #(
   parameter int DATA_W     = 256,
   parameter int ADDR_W     = 48,
   parameter int LEN_W      = 32,
   parameter int MAX_BURST  = 16,
   parameter int FIFO_DEPTH = 64
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  num_beats,
   output logic              busy,
   output logic              done,
   output logic              error,
   read_axi256_if.master     bus
);
   localparam int BURST_W = $clog2(MAX_BURST) + 1;
   localparam int CRED_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int PTR_W   = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FINISH} state_t;

   state_t            state;
   logic [ADDR_W-1:0] addr_q;
   logic [LEN_W-1:0]  issue_rem;
   logic [LEN_W-1:0]  total_q;
   logic [LEN_W-1:0]  out_cnt;
   logic [CRED_W-1:0] credits;
   logic [BURST_W-1:0] len_q;
   logic [BURST_W-1:0] len_calc;
   logic              arvalid_q;
   logic [ADDR_W-1:0] araddr_q;
   logic [7:0]        arlen_q;
   logic [7:0]        to_4k;
   logic [LEN_W-1:0]  cand;
   logic              ar_hs;
   logic              r_hs;
   logic              s_hs;
   logic              last_out;
   logic              fifo_empty;
   logic [PTR_W:0]    wr_ptr;
   logic [PTR_W:0]    rd_ptr;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic              unused_bits;

   assign unused_bits = &{1'b0, base_addr[4:0], bus.m_axi_rlast};

   // beats left before the next 4 KiB page: 1..128
   assign to_4k = 8'd128 - {1'b0, addr_q[11:5]};

   always_comb begin
      cand = LEN_W'(MAX_BURST);
      if (issue_rem < cand) cand = issue_rem;
      if (LEN_W'(to_4k) < cand) cand = LEN_W'(to_4k);
      len_calc = BURST_W'(cand);
   end

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign ar_hs      = arvalid_q & bus.m_axi_arready;
   assign r_hs       = bus.m_axi_rvalid & busy;
   assign s_hs       = ~fifo_empty & bus.m_axis_tready;
   assign last_out   = s_hs & ((out_cnt + LEN_W'(1)) == total_q);

   assign bus.m_axi_araddr  = araddr_q;
   assign bus.m_axi_arlen   = arlen_q;
   assign bus.m_axi_arsize  = 3'b101;
   assign bus.m_axi_arburst = 2'b01;
   assign bus.m_axi_arvalid = arvalid_q;
   assign bus.m_axi_rready  = busy;
   assign bus.m_axis_tvalid = ~fifo_empty;
   assign bus.m_axis_tdata  = fifo_empty ? '0 : mem[rd_ptr[PTR_W-1:0]];
   assign bus.m_axis_tlast  = ~fifo_empty & (out_cnt == (total_q - LEN_W'(1)));

   always_ff @(posedge clock) begin
      if (r_hs) mem[wr_ptr[PTR_W-1:0]] <= bus.m_axi_rdata;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (r_hs) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         if (s_hs) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         addr_q    <= '0;
         issue_rem <= '0;
         total_q   <= '0;
         out_cnt   <= '0;
         credits   <= CRED_W'(FIFO_DEPTH);
         len_q     <= '0;
         arvalid_q <= 1'b0;
         araddr_q  <= '0;
         arlen_q   <= '0;
      end else begin
         done    <= 1'b0;
         // credits = free FIFO slots not yet promised to an issued burst
         credits <= credits - (ar_hs ? CRED_W'(len_q) : '0) + (s_hs ? CRED_W'(1) : '0);
         out_cnt <= out_cnt + LEN_W'(s_hs);
         if (r_hs && (bus.m_axi_rresp != 2'b00)) error <= 1'b1;

         case (state)
            S_IDLE: begin
               if (start) begin
                  error     <= 1'b0;
                  busy      <= 1'b1;
                  addr_q    <= {base_addr[ADDR_W-1:5], 5'b0};
                  issue_rem <= num_beats;
                  total_q   <= num_beats;
                  out_cnt   <= '0;
                  state     <= (num_beats == '0) ? S_FINISH : S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (arvalid_q) begin
                  if (bus.m_axi_arready) begin
                     arvalid_q <= 1'b0;
                     addr_q    <= addr_q + (ADDR_W'(len_q) << 5);
                     issue_rem <= issue_rem - LEN_W'(len_q);
                     if (issue_rem == LEN_W'(len_q)) state <= S_DRAIN;
                  end
               end else if (credits >= CRED_W'(len_calc)) begin
                  arvalid_q <= 1'b1;
                  araddr_q  <= addr_q;
                  arlen_q   <= 8'(len_calc - BURST_W'(1));
                  len_q     <= len_calc;
               end
            end
            S_DRAIN: begin
               if (last_out) state <= S_FINISH;
            end
            S_FINISH: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_read_axi256.sv
// Self-checking bench for read_axi256: DDR slave model, stream scoreboard and directed corner cases.
module tb_read_axi256;
   localparam int ADDR_W = 48;
   localparam int DATA_W = 256;
   localparam int LEN_W  = 32;

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [LEN_W-1:0]  num_beats = '0;
   logic              busy, done, error;

   read_axi256_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   read_axi256 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
                 .MAX_BURST(16), .FIFO_DEPTH(64)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr),
      .num_beats(num_beats), .busy(busy), .done(done), .error(error), .bus(bus));

   always #5 clock = ~clock;

   int total = 0;
   int bad = 0;

   typedef struct { logic [47:0] addr; int len; } ar_t;
   typedef struct { logic [47:0] addr; bit last; } beat_t;
   typedef struct {
      logic [47:0] base; int n; int err_beat; int mode;
      int exp_n_ar; int exp_first_len; bit exp_err;
   } vec_t;

   ar_t   exp_ar_q[$];
   beat_t pend_q[$];
   logic [47:0] exp_base = '0;
   int exp_n = 0, out_idx = 0, r_idx = 0, err_beat = -1;
   int ar_seen = 0, first_len = -1, issued = 0, stall_cnt = 0;
   int tready_mode = 1;
   bit slave_rand = 1'b0;
   bit r_hold = 1'b0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] data_of(input logic [47:0] a);
      logic [31:0] w;
      w = a[36:5] ^ 32'h5A3C_96E1;
      return {8{w}};
   endfunction

   // Reference burst plan: greedy split by 16 beats, remaining count and the 4 KiB page edge.
   task automatic plan(input logic [47:0] base, input int n);
      logic [47:0] a;
      int rem, l, room;
      exp_ar_q.delete();
      a = base & ~48'h1F;
      exp_base = a;
      rem = n;
      while (rem > 0) begin
         room = (4096 - int'(a[11:0])) / 32;
         l = 16;
         if (rem < l) l = rem;
         if (room < l) l = room;
         exp_ar_q.push_back('{a, l});
         a += 48'(l * 32);
         rem -= l;
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_error"}, error, 0);
      chk({tag, "_arvalid"}, bus.m_axi_arvalid, 0);
      chk({tag, "_rready"}, bus.m_axi_rready, 0);
      chk({tag, "_tvalid"}, bus.m_axis_tvalid, 0);
      chk({tag, "_tlast"}, bus.m_axis_tlast, 0);
      chk({tag, "_araddr"}, bus.m_axi_araddr, 0);
      chk({tag, "_arlen"}, bus.m_axi_arlen, 0);
   endtask

   task automatic begin_xfer(input logic [47:0] base, input int n, input int eb);
      plan(base, n);
      exp_n = n; out_idx = 0; r_idx = 0; err_beat = eb;
      ar_seen = 0; first_len = -1; issued = 0; stall_cnt = 0;
      @(posedge clock); #1;
      start = 1'b1; base_addr = base; num_beats = n;
      @(posedge clock); #1;
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("error_cleared_on_start", error, 0);
   endtask

   task automatic wait_done(input int budget);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(posedge clock); #1;
         if (done) begin seen = 1'b1; break; end
      end
      chk("done_seen", seen, 1);
      if (!seen) begin
         reset_n = 1'b0;
         @(posedge clock); #1;
         reset_n = 1'b1;
         return;
      end
      chk("busy_drops_with_done", busy, 0);
      chk("beats_streamed", out_idx, exp_n);
      chk("ars_outstanding", exp_ar_q.size(), 0);
      chk("r_never_stalled", stall_cnt, 0);
      @(posedge clock); #1;
      chk("done_one_cycle", done, 0);
   endtask

   task automatic run_transfer(input logic [47:0] base, input int n, input int eb, input int mode,
                               output int n_ar, output int flen, output bit err);
      tready_mode = mode;
      slave_rand = (mode == 2);
      begin_xfer(base, n, eb);
      wait_done(20000);
      n_ar = ar_seen; flen = first_len; err = error;
   endtask

   // Slave/scoreboard: everything is driven and booked at the falling edge for the next rising edge.
   initial begin : slave
      beat_t cur;
      ar_t e;
      bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b0; bus.m_axi_rdata = '0;
      bus.m_axi_rresp = 2'b00; bus.m_axi_rlast = 1'b0; bus.m_axis_tready = 1'b0;
      forever begin
         @(negedge clock);
         if (!reset_n) begin
            pend_q.delete();
            r_hold = 1'b0;
            bus.m_axi_rvalid = 1'b0; bus.m_axi_rlast = 1'b0; bus.m_axi_rresp = 2'b00;
            bus.m_axi_arready = 1'b0; bus.m_axis_tready = 1'b0;
         end else begin
            if (!r_hold) begin
               if (pend_q.size() > 0 && (!slave_rand || ($urandom % 4) != 0)) begin
                  cur = pend_q[0];
                  bus.m_axi_rvalid = 1'b1;
                  bus.m_axi_rdata  = data_of(cur.addr);
                  bus.m_axi_rlast  = cur.last;
                  bus.m_axi_rresp  = (r_idx == err_beat) ? 2'd2 : 2'd0;
               end else begin
                  bus.m_axi_rvalid = 1'b0; bus.m_axi_rlast = 1'b0; bus.m_axi_rresp = 2'b00;
               end
            end
            if (bus.m_axi_rvalid) begin
               if (bus.m_axi_rready) begin
                  pend_q.delete(0);
                  r_idx++;
                  r_hold = 1'b0;
               end else begin
                  r_hold = 1'b1;
                  if (busy) stall_cnt++;
               end
            end

            bus.m_axi_arready = slave_rand ? (($urandom % 3) != 0) : 1'b1;
            if (bus.m_axi_arvalid && bus.m_axi_arready) begin
               ar_seen++;
               if (first_len < 0) first_len = int'(bus.m_axi_arlen);
               if (exp_ar_q.size() == 0) begin
                  chk("unexpected_ar", bus.m_axi_araddr, 0);
               end else begin
                  e = exp_ar_q.pop_front();
                  chk("araddr", bus.m_axi_araddr, e.addr);
                  chk("arlen", bus.m_axi_arlen, e.len - 1);
               end
               chk("arsize", bus.m_axi_arsize, 3'b101);
               chk("arburst", bus.m_axi_arburst, 2'b01);
               issued += int'(bus.m_axi_arlen) + 1;
               chk("credit_bound", (issued - out_idx) <= 64, 1);
               for (int k = 0; k <= int'(bus.m_axi_arlen); k++)
                  pend_q.push_back('{bus.m_axi_araddr + 48'(32 * k), (k == int'(bus.m_axi_arlen))});
            end

            case (tready_mode)
               0:       bus.m_axis_tready = 1'b0;
               1:       bus.m_axis_tready = 1'b1;
               default: bus.m_axis_tready = 1'($urandom % 2);
            endcase
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
               if (out_idx >= exp_n) begin
                  chk("extra_stream_beat", out_idx, exp_n - 1);
               end else begin
                  chk("tdata", bus.m_axis_tdata, data_of(exp_base + 48'(32 * out_idx)));
                  chk("tlast", bus.m_axis_tlast, out_idx == exp_n - 1);
               end
               out_idx++;
            end
         end
      end
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      vec_t vecs[8];
      int n_ar, flen, n;
      bit err;
      logic [47:0] rb;
      int eb;
      bit reached;

      vecs[0] = '{48'h1000,     40,  -1, 1, 3,  15, 1'b0};
      vecs[1] = '{48'h0FC0,     4,   -1, 1, 2,  1,  1'b0};
      vecs[2] = '{48'h0FE0,     3,   -1, 2, 2,  0,  1'b0};
      vecs[3] = '{48'h1234,     1,   -1, 1, 1,  0,  1'b0};
      vecs[4] = '{48'h2000,     20,   5, 2, 2,  15, 1'b1};
      vecs[5] = '{48'h0,        0,   -1, 1, 0,  -1, 1'b0};
      vecs[6] = '{48'h0,        300, -1, 2, 19, 15, 1'b0};
      vecs[7] = '{48'hFFFFFE0,  17,  -1, 2, 2,  0,  1'b0};

      repeat (3) @(posedge clock);
      #1;
      chk_reset_outputs("reset");
      reset_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_transfer(vecs[i].base, vecs[i].n, vecs[i].err_beat, vecs[i].mode, n_ar, flen, err);
         chk($sformatf("vec%0d_n_ar", i), n_ar, vecs[i].exp_n_ar);
         chk($sformatf("vec%0d_first_len", i), flen, vecs[i].exp_first_len);
         chk($sformatf("vec%0d_error", i), err, vecs[i].exp_err);
      end

      // zero length: done two cycles after start, busy only in between
      tready_mode = 1; slave_rand = 1'b0;
      begin_xfer(48'h40, 0, -1);
      chk("zero_done_early", done, 0);
      @(posedge clock); #1;
      chk("zero_done", done, 1);
      chk("zero_busy_low", busy, 0);
      @(posedge clock); #1;
      chk("zero_done_once", done, 0);
      chk("zero_no_ar", ar_seen, 0);

      // backpressure: credits cap issue at 64 beats; start while busy is ignored
      tready_mode = 0; slave_rand = 1'b0;
      begin_xfer(48'h10000, 200, -1);
      repeat (500) @(posedge clock);
      #1;
      chk("bp_ar_count", ar_seen, 4);
      chk("bp_arvalid_low", bus.m_axi_arvalid, 0);
      chk("bp_r_drained", pend_q.size(), 0);
      chk("bp_tvalid", bus.m_axis_tvalid, 1);
      start = 1'b1; base_addr = 48'h0; num_beats = 5;
      @(posedge clock); #1;
      start = 1'b0;
      chk("bp_busy_kept", busy, 1);
      tready_mode = 1;
      wait_done(5000);
      chk("bp_ar_total", ar_seen, 13);

      // reset mid-transfer, then a clean transfer proving credits were restored
      tready_mode = 2; slave_rand = 1'b1;
      begin_xfer(48'h20000, 100, -1);
      reached = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         @(posedge clock); #1;
         if (out_idx >= 10) begin reached = 1'b1; break; end
      end
      chk("mid_reached_beat10", reached, 1);
      reset_n = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      @(posedge clock); @(posedge clock); #1;
      reset_n = 1'b1;
      tready_mode = 0; slave_rand = 1'b0;
      begin_xfer(48'h30000, 100, -1);
      repeat (200) @(posedge clock);
      #1;
      chk("post_reset_credit_ars", ar_seen, 4);
      tready_mode = 1;
      wait_done(5000);
      chk("post_reset_error", error, 0);

      // randomized transfers against the reference plan and scoreboard
      for (int i = 0; i < 6; i++) begin
         rb = {16'($urandom), 32'($urandom)};
         n = int'($urandom_range(1, 150));
         eb = (($urandom % 2) != 0) ? int'($urandom_range(0, n - 1)) : -1;
         run_transfer(rb, n, eb, 2, n_ar, flen, err);
         chk($sformatf("rand%0d_error", i), err, eb >= 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/read_axi256.md
Name: read_axi256

Overview:
- AXI4 memory-mapped read master that fetches a contiguous block of 256-bit words from DDR and emits them as a 256-bit AXI4-Stream with TLAST on the final word.
- Counterpart to the write_axi256 capture path: write_axi256 stores streams into memory, and read_axi256 plays captured IQ buffers back from memory into the fabric.
- Bursts are issued against a credit-controlled output FIFO, so R-channel data is never stalled by downstream backpressure.

Parameters:
- DATA_W, 256, data width of R channel and stream (bytes per beat = 32).
- ADDR_W, 48, AXI address width.
- LEN_W, 32, width of the beat-count input.
- MAX_BURST, 16, maximum beats per AR burst (power of two, 1..256).
- FIFO_DEPTH, 64, output FIFO depth in beats (power of two, >= MAX_BURST).

Ports:
- clock  in  1  rising-edge clock for all logic.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only when busy=0.
- base_addr  in  ADDR_W  start byte address; bits [4:0] are ignored and treated as 0.
- num_beats  in  LEN_W  number of 256-bit words to read.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse after the last stream beat handshakes.
- error  out  1  sticky; set by any RRESP != 0, cleared on the next accepted start.
- m_axi_araddr  out  ADDR_W  burst start address.
- m_axi_arlen  out  8  beats-1.
- m_axi_arsize  out  3  constant 3'b101.
- m_axi_arburst  out  2  constant INCR (2'b01).
- m_axi_arvalid  out  1  AR valid.
- m_axi_arready  in  1  AR ready.
- m_axi_rdata  in  DATA_W  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rlast  in  1  last beat of burst.
- m_axi_rvalid  in  1  R valid.
- m_axi_rready  out  1  R ready.
- m_axis_tdata  out  DATA_W  stream data.
- m_axis_tlast  out  1  high on the final word of the transfer.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - FSM goes to IDLE; FIFO is flushed and credits are set to FIFO_DEPTH.
  - Outputs: busy=0, done=0, error=0, arvalid=0, rready=0, tvalid=0, tlast=0, araddr=0, arlen=0.
  - Reset mid-transfer abandons the transfer; the interconnect must be reset in the same domain.
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
  - IDLE: on start with num_beats>0, latch the address (low 5 bits zeroed) and the count, clear error, set busy, go to ISSUE.
  - IDLE: on start with num_beats=0, go directly to FINISH; no AR is issued.
  - ISSUE: compute len = min(MAX_BURST, beats remaining to issue, beats to the next 4 KiB boundary (128 - addr[11:5])).
  - ISSUE: assert arvalid only when credits >= len, and hold araddr/arlen stable until arready.
  - ISSUE, on AR handshake: credits -= len, addr += len*32, remaining -= len. When remaining reaches 0, go to DRAIN.
  - DRAIN: wait until every requested beat has left the stream port, then go to FINISH.
  - FINISH: done=1 for exactly one cycle, busy drops in the same cycle, return to IDLE.
- One AR is in flight at a time in the AR channel; multiple bursts may be outstanding on R, bounded only by credits.
- rready=1 whenever busy=1. Credits guarantee FIFO space, so a FIFO write on R handshake never overflows.
- RRESP != 0 sets error; the data is still forwarded. RLAST is not used for counting.
- Stream output:
  - FIFO is first-word fall-through; tvalid = FIFO not empty.
  - On each tvalid&tready: credits += 1, output counter += 1.
  - tlast=1 on output beat index num_beats-1.
- Credits: simultaneous AR reservation and stream release in one cycle give credits = credits - len + 1.
- Latency: arvalid rises at the earliest 1 cycle after start. First tvalid comes 1 cycle after the first R handshake.
- start while busy=1 is ignored.
- All counters are LEN_W wide and do not wrap for num_beats <= 2^LEN_W-1.

Test Plan:
- Basic transfer: base=0x1000, num_beats=40, tready=1, zero-wait slave -> AR lens 15,15,7 (beats-1) at 0x1000, 0x1200, 0x1400. Stream carries 40 words in address order, tlast on the 40th, done pulses once, error=0.
- 4 KiB boundary split: base=0x0FC0, num_beats=4 -> ARs of 2 beats at 0x0FC0 and 2 beats at 0x1000; no burst crosses 0x1000.
- Backpressure: num_beats=200, tready=0 for 500 cycles -> exactly 4 bursts (64 credits) are issued and then arvalid stays 0. After tready=1, all 200 words arrive with no drops; R is never stalled while busy.
- Error response: a slave returns RRESP=2 on beat 5 of 20 -> all 20 words are still streamed, error=1 stays after done, and error clears on the next start.
- Zero length: num_beats=0 -> no arvalid, done pulses 2 cycles after start, busy is high for exactly those cycles.
- Reset mid-transfer: deassert reset_n during beat 10 of 100 -> all outputs go to 0 immediately, credits read 64. A new start after release completes normally.
